// File: rtl/seg_scan_driver.sv
// Eight-digit common-anode seven-segment scanner. It takes a once-per-frame
// snapshot of the 32-bit segdata bus and blanks all anodes at the start of each slot.
module seg_scan_driver #(
  parameter int unsigned REFRESH_DIV  = 25000,
  parameter int unsigned BLANK_CYCLES = 250,
  parameter logic [7:0]  DP_MASK      = 8'b0000_0100
) (
  input  logic        segclk,
  input  logic        resetn,
  input  logic [31:0] segdata,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_done
);

  localparam int unsigned     CNT_W     = $clog2(REFRESH_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYCLES);

  // Team glyph set, active-low {g,f,e,d,c,b,a}.
  function automatic logic [6:0] decode(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h7F;
      4'hB: s = 7'h2B;
      4'hC: s = 7'h23;
      4'hD: s = 7'h06;
      4'hE: s = 7'h0C;
      default: s = 7'h77;
    endcase
    return s;
  endfunction

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [31:0]      shadow_q, shadow_d;
  logic [7:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;
  logic             dp_q, dp_d;
  logic             fd_q, fd_d;
  logic             slot_end, frame_end, in_blank;
  logic [3:0]       nib;

  always_comb begin
    slot_end  = (cnt_q == CNT_LAST);
    frame_end = slot_end && (idx_q == 3'd7);
    cnt_d     = slot_end ? '0 : cnt_q + CNT_W'(1);
    idx_d     = slot_end ? idx_q + 3'd1 : idx_q;
    // Snapshot only at the frame boundary so a digit never tears mid-frame.
    shadow_d  = frame_end ? segdata : shadow_q;
    fd_d      = frame_end;

    in_blank  = (BLANK_CYCLES != 0) && (cnt_q < BLANK_END);
    nib       = shadow_q[{idx_q, 2'b00} +: 4];
    an_d      = 8'hFF;
    seg_d     = 7'h7F;
    dp_d      = 1'b1;
    if (!in_blank) begin
      an_d  = ~(8'b1 << idx_q);
      seg_d = decode(nib);
      dp_d  = ~DP_MASK[idx_q];
    end
  end

  always_ff @(posedge segclk or negedge resetn) begin
    if (!resetn) begin
      cnt_q    <= '0;
      idx_q    <= 3'd0;
      shadow_q <= 32'hAAAA_AAAA;
      an_q     <= 8'hFF;
      seg_q    <= 7'h7F;
      dp_q     <= 1'b1;
      fd_q     <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      an_q     <= an_d;
      seg_q    <= seg_d;
      dp_q     <= dp_d;
      fd_q     <= fd_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver with an 8-cycle slot and a 2-cycle blank.
module tb_seg_scan_driver;

  localparam int unsigned RDIV  = 8;
  localparam int unsigned BLANK = 2;
  localparam logic [7:0]  DPM   = 8'b0000_0100;

  logic        segclk;
  logic        resetn;
  logic [31:0] segdata;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_done;

  int checks = 0;
  int errors = 0;

  seg_scan_driver #(
    .REFRESH_DIV (RDIV),
    .BLANK_CYCLES(BLANK),
    .DP_MASK     (DPM)
  ) dut (
    .segclk    (segclk),
    .resetn    (resetn),
    .segdata   (segdata),
    .an        (an),
    .seg       (seg),
    .dp        (dp),
    .frame_done(frame_done)
  );

  initial segclk = 1'b0;
  always #5 segclk = ~segclk;

  task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s k=%0d observed=%h expected=%h", tag, k, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge segclk);
    #1;
  endtask

  // Runs nsteps cycles from the start of a frame (cnt=0, idx=0). glyphs packs
  // the expected digit segments as {d7,...,d0}. Optionally changes segdata
  // just before cycle change_k.
  task automatic run_frame(input logic [55:0] glyphs, input int nsteps,
                           input int change_k, input logic [31:0] change_val);
    int c, i;
    logic [7:0] e_an;
    logic [6:0] e_seg;
    logic       e_dp;
    for (int k = 1; k <= nsteps; k++) begin
      if (k == change_k) segdata = change_val;
      step();
      c = (k - 1) % RDIV;
      i = (k - 1) / RDIV;
      if (c < BLANK) begin
        e_an = 8'hFF; e_seg = 7'h7F; e_dp = 1'b1;
      end else begin
        e_an = ~(8'b1 << i); e_seg = glyphs[i*7 +: 7]; e_dp = ~DPM[i];
      end
      chk("an", k, {24'd0, an}, {24'd0, e_an});
      chk("seg", k, {25'd0, seg}, {25'd0, e_seg});
      chk("dp", k, {31'd0, dp}, {31'd0, e_dp});
      chk("frame_done", k, {31'd0, frame_done}, {31'd0, (k == RDIV*8)});
      chk("an_onehot", k, $countones(~an), (e_an == 8'hFF) ? 0 : 1);
    end
  endtask

  localparam logic [55:0] G_BLANK = {8{7'h7F}};
  localparam logic [55:0] G_1234  = {7'h40, 7'h40, 7'h40, 7'h40, 7'h79, 7'h24, 7'h30, 7'h19};
  localparam logic [55:0] G_NONE  = {7'h2B, 7'h23, 7'h2B, 7'h06, 7'h40, 7'h40, 7'h40, 7'h40};
  localparam logic [55:0] G_U1PU  = {7'h77, 7'h79, 7'h0C, 7'h77, 7'h40, 7'h40, 7'h40, 7'h40};
  localparam logic [55:0] G_9876  = {7'h10, 7'h00, 7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24};

  initial begin
    resetn  = 1'b0;
    segdata = 32'h0000_1234;
    step();
    step();
    chk("rst_an", 0, {24'd0, an}, 32'h0000_00FF);
    chk("rst_seg", 0, {25'd0, seg}, 32'h0000_007F);
    chk("rst_dp", 0, {31'd0, dp}, 32'd1);
    chk("rst_fd", 0, {31'd0, frame_done}, 32'd0);
    resetn = 1'b1;

    // Frame 1 still shows the blank reset snapshot.
    run_frame(G_BLANK, 64, 0, 32'h0);
    // Frame 2 shows 1234; the change made during it must not appear yet.
    run_frame(G_1234, 64, 1, 32'hBCBD_0000);
    // Frame 3 shows "nonE"; the change at cycle 20 waits for the next frame.
    run_frame(G_NONE, 64, 21, 32'hF1EF_0000);
    // Frame 4 shows "_1P_"; segdata changed on the snapshot cycle is captured.
    run_frame(G_U1PU, 64, 64, 32'h9876_5432);
    // Frame 5 up to digit 5 drive, then an asynchronous reset mid-slot.
    run_frame(G_9876, 44, 0, 32'h0);
    chk("pre_rst_an", 44, {24'd0, an}, 32'h0000_00DF);
    resetn = 1'b0;
    #1;
    chk("async_an", 0, {24'd0, an}, 32'h0000_00FF);
    chk("async_seg", 0, {25'd0, seg}, 32'h0000_007F);
    chk("async_dp", 0, {31'd0, dp}, 32'd1);
    chk("async_fd", 0, {31'd0, frame_done}, 32'd0);
    step();
    resetn = 1'b1;
    // Scan restarts at digit 0 with a blank shadow, then shows held data.
    run_frame(G_BLANK, 64, 0, 32'h0);
    run_frame(G_9876, 64, 0, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
